// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: two requesters share one bitwise logic unit through a
// round-robin arbiter; results land in a single registered output stage
// with requester ID, zero flag and valid/ready backpressure.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_zero,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t             state_q, state_d;
    logic               rr_last_q, rr_last_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               id_q, id_d;
    logic               zero_q, zero_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               can_accept;
    logic               gnt0, gnt1;
    logic               xfer0, xfer1, xfer;
    logic [2:0]         sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b, result;

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return ~(a ^ b);
            3'b110:  return ~a;
            default: return (~a) + WIDTH'(1);
        endcase
    endfunction

    // Arbitration and handshake: rr_last_q holds the last granted requester,
    // so on contention the other one wins.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || out_ready;
        gnt0       = req0_valid && (!req1_valid || rr_last_q);
        gnt1       = req1_valid && (!req0_valid || !rr_last_q);
        req0_ready = rst_n && gnt0 && can_accept;
        req1_ready = rst_n && gnt1 && can_accept;
        xfer0      = req0_valid && req0_ready;
        xfer1      = req1_valid && req1_ready;
        xfer       = xfer0 || xfer1;
        sel_op     = xfer1 ? req1_op : req0_op;
        sel_a      = xfer1 ? req1_a  : req0_a;
        sel_b      = xfer1 ? req1_b  : req0_b;
        result     = logic_op(sel_op, sel_a, sel_b);
    end

    // State register: output stage, RR pointer and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            rr_last_q <= 1'b1;
            data_q    <= '0;
            id_q      <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            data_q    <= data_d;
            id_q      <= id_d;
            zero_q    <= zero_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic for the EMPTY/FULL output stage.
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = ST_FULL;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Datapath updates: load result on transfer; otherwise hold (data kept when draining).
    always_comb begin
        rr_last_d = rr_last_q;
        data_d    = data_q;
        id_d      = id_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        if (xfer) begin
            rr_last_d = xfer1;
            data_d    = result;
            id_d      = xfer1;
            zero_d    = (result == '0);
            cnt_d     = cnt_q + CNT_W'(1);
        end
    end

    // Output drive from registered state.
    always_comb begin
        out_valid = (state_q == ST_FULL);
        out_data  = data_q;
        out_id    = id_q;
        out_zero  = zero_q;
        op_count  = cnt_q;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit between two requesters using round-robin arbitration and valid/ready handshakes.
- The unit covers AND, OR, XOR, NAND, NOR, XNOR, NOT and two's-complement.
- Results go through a single registered output stage that carries the requester ID, a zero flag and backpressure.
- The block sits between the instruction-issue logic and the writeback path.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_op  input  3  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as the requester 0 ports, for requester 1.
- out_valid  output  1  result register holds a valid result.
- out_data  output  WIDTH  result.
- out_id  output  1  requester that issued the result.
- out_zero  output  1  out_data == 0.
- out_ready  input  1  consumer takes the result this cycle.
- op_count  output  CNT_W  number of accepted operations, wrapping.

Behaviour:
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT a (b ignored)
  - 111 two's-complement of a, i.e. (~a)+1 truncated to WIDTH (b ignored). 0 maps to 0; 0x80000000 maps to 0x80000000.
- Reset (rst_n low at a clock edge):
  - out_valid=0, out_data=0, out_id=0, out_zero=0, op_count=0.
  - Round-robin pointer set so requester 0 has priority.
  - Any held result is discarded, including one held mid-backpressure.
  - No req*_ready is asserted while rst_n is low.
- can_accept = !out_valid || out_ready (combinational).
- Grant (combinational):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester not granted at the last accepted transfer (round-robin).
  - Neither valid: no grant.
- reqN_ready = grantN && can_accept. At most one ready per cycle. Ready never depends on reqN_ready itself.
- A transfer occurs when reqN_valid && reqN_ready. On the next edge:
  - out_data gets the computed result; out_id gets N; out_zero gets (result==0).
  - out_valid is set to 1; op_count increments by 1, wrapping modulo 2^CNT_W.
  - The RR pointer records N.
- Latency: one cycle from accept to out_valid.
- Throughput: one operation per cycle when out_ready is held high.
- Output register states:
  - EMPTY (out_valid=0): accepts any granted request.
  - FULL (out_valid=1):
    - out_ready=1 with a new transfer: loads the new result, stays FULL.
    - out_ready=1 with no transfer: goes EMPTY; out_data keeps its last value.
    - out_ready=0: holds all outputs stable; both readies are 0.
- The RR pointer changes only on an accepted transfer, never on a stall or idle cycle.
- Requesters must hold valid/op/a/b stable until ready. The block does not check this.
- A requester dropping valid before ready has no effect on state.
- Reset mid-backpressure: a result pending with out_ready=0 is dropped. After reset, requester 0 wins the first contention.

Test Plan:
- Reset, then req0 op=000, a=0xF0F0_F0F0, b=0xFF00_FF00, out_ready=1 -> req0_ready=1 that cycle; next cycle out_valid=1, out_data=0xF000_F000, out_id=0, op_count=1.
- Both requesters valid continuously with out_ready=1:
  - req0 op=010, a=b=0x1234_5678; req1 op=110, a=0.
  - Required: grants alternate 0,1,0,1.
  - Results alternate 0x0000_0000 (out_zero=1) and 0xFFFF_FFFF (out_zero=0).
  - After 4 transfers op_count=4.
- Two's-complement, op=111:
  - a=0x0000_0001 -> 0xFFFF_FFFF.
  - a=0 -> 0, out_zero=1.
  - a=0x8000_0000 -> 0x8000_0000.
- Backpressure:
  - Accept one operation, then hold out_ready=0 for 3 cycles with both requesters valid -> both readies 0; out_data/out_id unchanged.
  - Raise out_ready -> the pending result is consumed and the next request is accepted in the same cycle.
  - The RR pointer did not advance during the stall.
- Reset during a stalled FULL state -> next cycle out_valid=0 and op_count=0. With both valid, requester 0 is granted first.
- Counter wrap: CNT_W=4 with 17 back-to-back accepted operations -> op_count=1. The remaining opcodes (001, 011, 100, 101) are checked against a per-opcode reference model with random operands.
